// File: rtl/decode_issue_ctrl.sv
// Decode-to-EX issue controller: load scoreboard, hazard stall, EX handshake,
// flush handling and a saturating stall-cycle counter.
//
// state | meaning
// RUN   | instruction issued, decode empty, or flushed last cycle
// HOLD  | valid instruction waiting only on EX backpressure
// HAZ   | valid instruction blocked by load-use RAW, load WAW or full load queue
module decode_issue_ctrl #(
  parameter int REG_NUM  = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              de_valid,
  input  logic              r_en_1,
  input  logic [ADDR_W-1:0] r_addr_1,
  input  logic              r_en_2,
  input  logic [ADDR_W-1:0] r_addr_2,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              w_is_load,
  input  logic              ex_allowin,
  input  logic              flush,
  input  logic              wb_load_valid,
  input  logic [ADDR_W-1:0] wb_load_addr,
  output logic              issue_valid,
  output logic              de_allowin,
  output logic              stall_raw,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HAZ  = 2'd2
  } state_t;

  state_t             state;
  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;
  logic [2:0]         load_cnt;
  logic               raw;
  logic               waw;
  logic               qfull;
  logic               load_issue;
  logic               stall_cycle;

  assign raw = (r_en_1 && (r_addr_1 != '0) && pending[r_addr_1]) ||
               (r_en_2 && (r_addr_2 != '0) && pending[r_addr_2]);
  assign waw   = w_is_load && (w_addr != '0) && pending[w_addr];
  assign qfull = w_is_load && (load_cnt == 3'(LOAD_MAX));

  // A same-cycle writeback deliberately does not unblock; forwarding is downstream.
  assign stall_raw   = de_valid & (raw | waw | qfull);
  assign issue_valid = de_valid & ~stall_raw & ex_allowin & ~flush;
  assign de_allowin  = ~de_valid | issue_valid | flush;
  assign load_issue  = issue_valid & w_is_load;
  assign stall_cycle = de_valid & ~issue_valid & ~flush;
  assign ctrl_state  = state;

  // Clear applied first so a same-register set in the same cycle wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_load_valid && (wb_load_addr != '0)) pending_nxt[wb_load_addr] = 1'b0;
    if (load_issue && (w_addr != '0))          pending_nxt[w_addr]       = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending  <= '0;
      load_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      case ({load_issue, wb_load_valid})
        2'b10:   load_cnt <= load_cnt + 3'd1;
        2'b01:   if (load_cnt != '0) load_cnt <= load_cnt - 3'd1;
        default: load_cnt <= load_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      if (flush || !de_valid || issue_valid) state <= RUN;
      else if (stall_raw)                    state <= HAZ;
      else                                   state <= HOLD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_cycle && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
